inst_fetch_buf: RTL and testbench
=================================

Name: inst_fetch_buf

Overview:
Parametrised instruction buffer between instruction memory and decode. It is the successor to the single-register old/NOP/mem instruction selector. Fetched words and their PCs are queued in a DEPTH-entry FIFO, and one instruction is presented to decode through an output register. Decode can hold the output (stall), inject a single NOP (bubble), or discard everything buffered (flush, on branch or jump).

Parameters:
XLEN, 32, width of instruction word and PC
DEPTH, 4, FIFO entries; power of two, >= 2
NOP, 32'h00000013, word driven whenever no real instruction is presented

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
mem_valid  in  1  mem_rdata/mem_pc carry a fetched instruction
mem_rdata  in  XLEN  fetched instruction word
mem_pc  in  XLEN  address of fetched word
mem_ready  out  1  buffer accepts a word this cycle
stall  in  1  decode holds current instruction
bubble  in  1  present NOP for one cycle without consuming
flush  in  1  discard buffered and presented instructions
inst  out  XLEN  instruction to decode (registered)
inst_pc  out  XLEN  PC of inst (registered)
inst_valid  out  1  1 = inst is a real fetched instruction, 0 = injected NOP
count  out  $clog2(DEPTH)+1  entries held in FIFO storage, excluding the output register

Behaviour:
- Control priority, evaluated each edge: rst > flush > stall > bubble > advance.
- rst: inst=NOP, inst_pc=0, inst_valid=0, read/write pointers=0, count=0. Any push in the same cycle is dropped.
- mem_ready = (count != DEPTH). It is combinational from count only; there is no path from stall, bubble or flush.
- Push:
  - Occurs when mem_valid && mem_ready && !flush && !rst.
  - A push with mem_ready=0 is ignored; the source must hold the word.
- Advance (no rst/flush/stall/bubble):
  - count>0: inst/inst_pc <= FIFO head, inst_valid<=1, read pointer +1.
  - count==0 with push: bypass. mem_rdata/mem_pc load directly into the output register, inst_valid<=1, and the FIFO is untouched. Latency from accepted word to inst is 1 cycle.
  - count==0, no push: inst<=NOP, inst_valid<=0, inst_pc unchanged.
- stall: inst, inst_pc and inst_valid hold. Pushes continue into the FIFO until full.
- bubble (stall=0): inst<=NOP, inst_valid<=0, inst_pc unchanged, no pop. Pushes are still accepted.
- flush: inst<=NOP, inst_valid<=0, pointers=0, count=0. A push in the same cycle is dropped. mem_ready during the flush cycle reflects the pre-flush count.
- Push and pop in the same cycle with count>0: count unchanged, FIFO order preserved.
- When full: a pop in cycle N frees the slot, and mem_ready rises in cycle N+1 (no same-cycle pass-through).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Reset mid-operation discards all contents, exactly like flush, and also clears inst_pc.

Test Plan:
1. Reset: rst=1 for 2 cycles with mem_valid=1 -> inst=0x00000013, inst_valid=0, count=0; mem_ready=1 after release, no word captured.
2. Bypass: empty buffer, push 0x00500093 @pc 0x100 -> next cycle inst=0x00500093, inst_pc=0x100, inst_valid=1, count=0.
3. Fill under stall (DEPTH=4): stall=1, source offers A..E -> A..D accepted, count=4, mem_ready=0, E held. Drop stall -> A,B,C,D appear one per cycle; mem_ready=1 one cycle after first pop; E accepted and emitted after D.
4. Bubble: FIFO holds A,B, bubble=1 for 1 cycle -> inst=NOP, inst_valid=0, count=2. Next cycle inst=A, count=1.
5. Flush with concurrent push: count=3, flush=1 and mem_valid=1 with W -> next cycle inst=NOP, inst_valid=0, count=0; W never appears on inst.
6. Wrap and ordering: 20 sequential words with pseudo-random stall/bubble/mem_valid -> inst_valid=1 sequence exactly equals the input order, no drop or duplicate, count within 0..4 throughout, pointers wrap ≥4 times.

Source files
------------

// File: rtl/inst_fetch_buf.sv
// Instruction buffer between instruction memory and decode: a DEPTH-entry FIFO
// of fetched words/PCs feeding a registered output stage with stall/bubble/flush control.
module inst_fetch_buf #(
    parameter int unsigned     XLEN  = 32,
    parameter int unsigned     DEPTH = 4,
    parameter logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    input  logic [XLEN-1:0]            mem_rdata,
    input  logic [XLEN-1:0]            mem_pc,
    output logic                       mem_ready,
    input  logic                       stall,
    input  logic                       bubble,
    input  logic                       flush,
    output logic [XLEN-1:0]            inst,
    output logic [XLEN-1:0]            inst_pc,
    output logic                       inst_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] store_word [DEPTH];
    logic [XLEN-1:0] store_pc   [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    logic push;
    logic advance;
    logic pop;
    logic bypass;
    logic fifo_write;

    // Full flag depends only on the stored count, never on decode controls.
    assign mem_ready = (count != CW'(DEPTH));

    // Decide this cycle's push, pop and whether an accepted word skips the FIFO.
    always_comb begin
        push       = 1'b0;
        advance    = 1'b0;
        pop        = 1'b0;
        bypass     = 1'b0;
        fifo_write = 1'b0;

        push       = mem_valid && mem_ready && !flush && !rst;
        advance    = !rst && !flush && !stall && !bubble;
        pop        = advance && (count != '0);
        bypass     = advance && (count == '0) && push;
        fifo_write = push && !bypass;
    end

    // FIFO storage carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (fifo_write) begin
            store_word[wr_ptr] <= mem_rdata;
            store_pc[wr_ptr]   <= mem_pc;
        end
    end

    // Pointers, occupancy and the decode-facing output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            inst       <= NOP;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            inst       <= NOP;
            inst_valid <= 1'b0;
        end else begin
            if (fifo_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            unique case ({fifo_write, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (pop) begin
                inst       <= store_word[rd_ptr];
                inst_pc    <= store_pc[rd_ptr];
                inst_valid <= 1'b1;
            end else if (bypass) begin
                inst       <= mem_rdata;
                inst_pc    <= mem_pc;
                inst_valid <= 1'b1;
            end else if (!stall) begin
                // Bubble, or nothing to present: NOP with the last PC kept.
                inst       <= NOP;
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: directed scenarios plus a randomized
// stall/bubble/valid phase, all checked against a queue-based reference model.
module tb_inst_fetch_buf;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] NOPW = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_valid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic [XLEN-1:0] mem_pc = '0;
    logic            mem_ready;
    logic            stall = 1'b0;
    logic            bubble = 1'b0;
    logic            flush = 1'b0;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_valid;
    logic [CW-1:0]   count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: FIFO contents as a queue of {pc, word}, plus the output stage.
    logic [63:0]     q[$];
    logic [XLEN-1:0] m_inst = NOPW;
    logic [XLEN-1:0] m_pc = '0;
    logic            m_valid = 1'b0;
    logic            m_new = 1'b0;
    logic            m_push = 1'b0;

    inst_fetch_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOPW)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_pc(mem_pc),
        .mem_ready(mem_ready),
        .stall(stall), .bubble(bubble), .flush(flush),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the currently driven inputs for one clock, advancing the model alongside.
    task automatic tick(input string tag);
        logic [63:0] head;
        logic        ready;
        ready  = (q.size() != DEPTH);
        if (!rst) chk({tag, ".ready"}, 64'(mem_ready), 64'(ready));
        m_push = mem_valid && ready && !flush && !rst;
        m_new  = 1'b0;
        if (rst) begin
            q.delete();
            m_inst = NOPW; m_pc = '0; m_valid = 1'b0;
        end else if (flush) begin
            q.delete();
            m_inst = NOPW; m_valid = 1'b0;
        end else if (stall) begin
            if (m_push) q.push_back({mem_pc, mem_rdata});
        end else if (bubble) begin
            if (m_push) q.push_back({mem_pc, mem_rdata});
            m_inst = NOPW; m_valid = 1'b0;
        end else if (q.size() > 0) begin
            head = q.pop_front();
            m_inst = head[31:0]; m_pc = head[63:32]; m_valid = 1'b1; m_new = 1'b1;
            if (m_push) q.push_back({mem_pc, mem_rdata});
        end else if (m_push) begin
            m_inst = mem_rdata; m_pc = mem_pc; m_valid = 1'b1; m_new = 1'b1;
        end else begin
            m_inst = NOPW; m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".inst"},  64'(inst),       64'(m_inst));
        chk({tag, ".pc"},    64'(inst_pc),    64'(m_pc));
        chk({tag, ".valid"}, 64'(inst_valid), 64'(m_valid));
        chk({tag, ".count"}, 64'(count),      64'(q.size()));
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p,
                         input logic s, input logic b, input logic f);
        mem_valid = v; mem_rdata = w; mem_pc = p; stall = s; bubble = b; flush = f;
    endtask

    initial begin
        int emit_n;
        int idx;
        logic [31:0] seq_w;

        // 1. Reset with a word offered: nothing captured.
        rst = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 32'h40, 1'b0, 1'b0, 1'b0);
        tick("rst0");
        tick("rst1");
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick("rst_rel");

        // 2. Bypass into an empty buffer.
        drive(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0, 1'b0);
        tick("bypass");

        // 3. Fill under stall, E held, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            tick("fill");
        end
        drive(1'b1, 32'hA000_0004, 32'h210, 1'b1, 1'b0, 1'b0);
        tick("full_hold");
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_ready", 64'(mem_ready), 64'(0));
        drive(1'b1, 32'hA000_0004, 32'h210, 1'b0, 1'b0, 1'b0);
        tick("pop_a");
        tick("pop_b_push_e");
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick("drain");

        // 4. Bubble holds the FIFO, then A resumes.
        drive(1'b1, 32'hB000_0000, 32'h300, 1'b1, 1'b0, 1'b0); tick("bub_ld_a");
        drive(1'b1, 32'hB000_0001, 32'h304, 1'b1, 1'b0, 1'b0); tick("bub_ld_b");
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);           tick("bubble");
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick("after_bub_a");
        tick("after_bub_b");
        tick("after_bub_idle");

        // 5. Flush with a concurrent push: W is dropped.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            tick("fl_ld");
        end
        drive(1'b1, 32'hEEEE_EEEE, 32'h4F0, 1'b0, 1'b0, 1'b1); tick("flush");
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick("post_flush0");
        tick("post_flush1");

        // 7. Reset mid-operation also clears inst_pc.
        drive(1'b1, 32'hD000_0000, 32'h500, 1'b0, 1'b0, 1'b0); tick("mid_ld0");
        drive(1'b1, 32'hD000_0001, 32'h504, 1'b1, 1'b0, 1'b0); tick("mid_ld1");
        drive(1'b1, 32'hD000_0002, 32'h508, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; tick("mid_rst");
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); tick("mid_rst_rel");

        // 6. Randomized wrap/ordering with 20 sequential words.
        emit_n = 0;
        idx = 0;
        for (int cyc = 0; cyc < 400 && emit_n < 20; cyc++) begin
            seq_w = 32'h7000_0000 + 32'(idx);
            drive((idx < 20) && ($urandom_range(0, 9) < 7), seq_w, 32'h800 + 32'(4 * idx),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, 1'b0);
            tick("rand");
            if (m_push) idx++;
            assert (count <= CW'(DEPTH)) else begin
                miscompares++;
                $error("FAIL rand.range: observed %0d expected <= %0d", count, DEPTH);
            end
            vectors++;
            if (m_new) begin
                chk("rand.order", 64'(inst), 64'(32'h7000_0000 + 32'(emit_n)));
                emit_n++;
            end
        end
        chk("rand.emitted", 64'(emit_n), 64'(20));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
